// File: rtl/cv32e40p_x_result_buffer.sv
// In-order buffer for coprocessor results headed for the execute stage's register-file write port.
// Entries drain when the ALU/MUL path leaves the port free, or are forced out on full or starvation.
module cv32e40p_x_result_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned X_ID_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        x_result_valid_i,
  output logic                        x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]       x_result_id_i,
  input  logic [4:0]                  x_result_rd_i,
  input  logic [31:0]                 x_result_data_i,
  input  logic                        x_result_we_i,
  input  logic                        alu_wb_req_i,
  output logic                        x_rvalid_o,
  output logic [4:0]                  x_rd_o,
  output logic [31:0]                 x_data_o,
  output logic [X_ID_WIDTH-1:0]       x_id_o,
  output logic [31:0]                 pending_rd_mask_o,
  output logic [$clog2(DEPTH):0]      fifo_count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = $clog2(MAX_WAIT + 1);

  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic [AW-1:0]         age_q;
  logic [4:0]            rd_mem   [DEPTH];
  logic [31:0]           data_mem [DEPTH];
  logic [X_ID_WIDTH-1:0] id_mem   [DEPTH];

  logic empty, full, push, grant;
  logic [PW-1:0] offset;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign x_result_ready_o = ~full & ~rst;
  // Handshakes that do not write a real register complete without occupying a slot.
  assign push  = x_result_valid_i & x_result_ready_o & x_result_we_i & (x_result_rd_i != 5'd0);
  assign grant = ~empty & (~alu_wb_req_i | (age_q == AW'(MAX_WAIT)) | full);

  assign x_rvalid_o   = grant;
  assign x_rd_o       = grant ? rd_mem[rd_ptr_q]   : '0;
  assign x_data_o     = grant ? data_mem[rd_ptr_q] : '0;
  assign x_id_o       = grant ? id_mem[rd_ptr_q]   : '0;
  assign fifo_count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (grant) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, grant})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Saturating at MAX_WAIT is what forces the next grant.
      if (grant || empty)
        age_q <= '0;
      else if (age_q != AW'(MAX_WAIT))
        age_q <= age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= x_result_rd_i;
      data_mem[wr_ptr_q] <= x_result_data_i;
      id_mem[wr_ptr_q]   <= x_result_id_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending_rd_mask_o = '0;
    offset            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q)
        pending_rd_mask_o[rd_mem[i]] = 1'b1;
    end
    pending_rd_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_cv32e40p_x_result_buffer.sv
// Scoreboard bench for cv32e40p_x_result_buffer: a queue model tracks stored results,
// occupancy, pending mask and grant age, and is compared against the DUT every cycle.
module tb_cv32e40p_x_result_buffer;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int IDW      = 4;

  logic            clk, rst;
  logic            x_result_valid_i, x_result_ready_o;
  logic [IDW-1:0]  x_result_id_i;
  logic [4:0]      x_result_rd_i;
  logic [31:0]     x_result_data_i;
  logic            x_result_we_i, alu_wb_req_i;
  logic            x_rvalid_o;
  logic [4:0]      x_rd_o;
  logic [31:0]     x_data_o;
  logic [IDW-1:0]  x_id_o;
  logic [31:0]     pending_rd_mask_o;
  logic [$clog2(DEPTH):0] fifo_count_o;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [4:0]     rd;
    logic [31:0]    data;
  } entry_t;

  entry_t sb[$];
  int     age_m;
  int     n_checks, n_fails;
  bit     mon_en;

  cv32e40p_x_result_buffer #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .X_ID_WIDTH(IDW)) dut (
    .clk               (clk),
    .rst               (rst),
    .x_result_valid_i  (x_result_valid_i),
    .x_result_ready_o  (x_result_ready_o),
    .x_result_id_i     (x_result_id_i),
    .x_result_rd_i     (x_result_rd_i),
    .x_result_data_i   (x_result_data_i),
    .x_result_we_i     (x_result_we_i),
    .alu_wb_req_i      (alu_wb_req_i),
    .x_rvalid_o        (x_rvalid_o),
    .x_rd_o            (x_rd_o),
    .x_data_o          (x_data_o),
    .x_id_o            (x_id_o),
    .pending_rd_mask_o (pending_rd_mask_o),
    .fifo_count_o      (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Per-cycle model check, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin : monitor
    logic [31:0] exp_mask;
    bit          exp_grant, exp_ready, empty_m;
    entry_t      e;
    if (mon_en) begin
      if (rst) begin
        checkOutput("rst_ready",  x_result_ready_o, 0);
        checkOutput("rst_count",  fifo_count_o, 0);
        checkOutput("rst_rvalid", x_rvalid_o, 0);
        checkOutput("rst_mask",   pending_rd_mask_o, 0);
        checkOutput("rst_data",   x_data_o, 0);
        sb.delete();
        age_m = 0;
      end else begin
        empty_m   = (sb.size() == 0);
        exp_ready = (sb.size() < DEPTH);
        exp_mask  = '0;
        foreach (sb[i]) exp_mask[sb[i].rd] = 1'b1;
        exp_grant = !empty_m && (!alu_wb_req_i || age_m == MAX_WAIT || sb.size() == DEPTH);
        checkOutput("count",  fifo_count_o, sb.size());
        checkOutput("ready",  x_result_ready_o, exp_ready);
        checkOutput("mask",   pending_rd_mask_o, exp_mask);
        checkOutput("rvalid", x_rvalid_o, exp_grant);
        if (x_rvalid_o) begin
          if (empty_m) checkOutput("rvalid_unexpected", x_rvalid_o, 0);
          else begin
            e = sb.pop_front();
            checkOutput("head_rd",   x_rd_o, e.rd);
            checkOutput("head_data", x_data_o, e.data);
            checkOutput("head_id",   x_id_o, e.id);
          end
        end else begin
          checkOutput("idle_rd",   x_rd_o, 0);
          checkOutput("idle_data", x_data_o, 0);
          checkOutput("idle_id",   x_id_o, 0);
        end
        if (exp_grant || empty_m) age_m = 0;
        else if (age_m < MAX_WAIT) age_m++;
        if (x_result_valid_i && exp_ready && x_result_we_i && x_result_rd_i != 5'd0)
          sb.push_back('{id: x_result_id_i, rd: x_result_rd_i, data: x_result_data_i});
      end
    end
  end

  // Present one result and hold it until the buffer takes it.
  task automatic applyStimulus(input logic [IDW-1:0] id, input logic [4:0] rd,
                               input logic [31:0] data, input logic we);
    bit hs;
    hs = 0;
    x_result_valid_i = 1'b1;
    x_result_id_i    = id;
    x_result_rd_i    = rd;
    x_result_data_i  = data;
    x_result_we_i    = we;
    for (int n = 0; n < 40; n++) begin
      hs = x_result_ready_o;
      @(posedge clk); #1;
      if (hs) break;
    end
    checkOutput("push_hs", hs, 1);
    x_result_valid_i = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    x_result_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitGrant(input string tag, input int exp_lat);
    int k;
    bit seen;
    seen = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (x_rvalid_o) begin seen = 1; break; end
    end
    checkOutput(tag, seen ? k : 0, exp_lat);
  endtask

  task automatic waitDrain(input string tag);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (fifo_count_o == 0) break;
    end
    checkOutput(tag, fifo_count_o, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_sb"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0; n_fails = 0; age_m = 0; mon_en = 1'b1;
    rst = 1'b1;
    x_result_valid_i = 0; x_result_id_i = '0; x_result_rd_i = '0;
    x_result_data_i = '0; x_result_we_i = 0; alu_wb_req_i = 0;
    #3;
    checkOutput("reset_ready", x_result_ready_o, 0);
    checkOutput("reset_count", fifo_count_o, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_ready", x_result_ready_o, 1);

    $display("[TB] idle pipe");
    alu_wb_req_i = 0;
    applyStimulus(4'd3, 5'd5, 32'hDEADBEEF, 1'b1);
    waitGrant("idle_latency", 1);
    checkOutput("idle_rd5",   x_rd_o, 5);
    checkOutput("idle_dbeef", x_data_o, 32'hDEADBEEF);
    checkOutput("idle_id3",   x_id_o, 3);
    checkOutput("idle_mask5", pending_rd_mask_o[5], 1);
    @(negedge clk);
    checkOutput("idle_after_count",  fifo_count_o, 0);
    checkOutput("idle_after_rvalid", x_rvalid_o, 0);
    @(posedge clk); #1;

    $display("[TB] starvation");
    alu_wb_req_i = 1;
    applyStimulus(4'd1, 5'd11, 32'h1111_0001, 1'b1);
    waitGrant("starve_latency", MAX_WAIT + 1);
    @(negedge clk);
    checkOutput("starve_after", x_rvalid_o, 0);
    @(posedge clk); #1;

    $display("[TB] full force");
    alu_wb_req_i = 1;
    for (int i = 0; i < 4; i++)
      applyStimulus(IDW'(i), 5'(12 + i), 32'hF000_0000 + i, 1'b1);
    checkOutput("full_ready",  x_result_ready_o, 0);
    checkOutput("full_grant",  x_rvalid_o, 1);
    applyStimulus(4'd4, 5'd16, 32'hF000_0004, 1'b1);
    waitDrain("full_drain");
    alu_wb_req_i = 0;

    $display("[TB] drop");
    applyStimulus(4'd5, 5'd9, 32'h0909_0909, 1'b0);
    applyStimulus(4'd6, 5'd0, 32'h0000_1234, 1'b1);
    idleCycles(3);
    checkOutput("drop_count", fifo_count_o, 0);
    checkOutput("drop_mask",  pending_rd_mask_o, 0);

    $display("[TB] duplicate rd");
    alu_wb_req_i = 1;
    applyStimulus(4'd7, 5'd7, 32'd1, 1'b1);
    applyStimulus(4'd8, 5'd7, 32'd2, 1'b1);
    checkOutput("dup_mask7", pending_rd_mask_o[7], 1);
    idleCycles(1);
    alu_wb_req_i = 0;
    waitDrain("dup_drain");

    $display("[TB] reset mid-operation");
    alu_wb_req_i = 1;
    for (int i = 0; i < 3; i++)
      applyStimulus(IDW'(9 + i), 5'(20 + i), 32'hABC0_0000 + i, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_count",  fifo_count_o, 0);
    checkOutput("midrst_mask",   pending_rd_mask_o, 0);
    checkOutput("midrst_rvalid", x_rvalid_o, 0);
    checkOutput("midrst_ready",  x_result_ready_o, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_release_ready", x_result_ready_o, 1);
    alu_wb_req_i = 0;
    idleCycles(15);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      x_result_valid_i = 1'($urandom_range(0, 1));
      x_result_we_i    = ($urandom_range(0, 9) != 0);
      x_result_rd_i    = 5'($urandom_range(0, 31));
      x_result_id_i    = IDW'($urandom);
      x_result_data_i  = $urandom;
      alu_wb_req_i     = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    x_result_valid_i = 0;
    alu_wb_req_i     = 0;
    waitDrain("rand_drain");

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
